// File: rtl/apb_top.sv
// apb_top: APB master and register-file slave joined by an internal APB bus.
//
// Ports
//   PCLK       system clock; all state updates on the rising edge
//   PRESETn    asynchronous active-low reset
//   transfer   request one APB transfer (sampled in IDLE and at back-to-back)
//   read       selects a read transfer
//   write      selects a write transfer; wins over read
//   apb_waddr  write byte address
//   apb_raddr  read byte address
//   apb_wdata  write data
//   apb_rdata  data returned by the last completed read
//   error      PSLVERR of the last completed transfer
//
// Optional build macro
//   APB_WAIT_STATE_EN  slave inserts one wait state in every ACCESS phase
//
// Master FSM
//   state  | meaning
//   IDLE   | bus quiet, waiting for transfer with read or write
//   SETUP  | PSEL high, command presented for one cycle
//   ACCESS | PSEL and PENABLE high until PREADY
//
// Slave register map (word aligned, PADDR[31:4] must be zero)
//   0x00 TX_DATA RW | 0x04 RX_DATA RO | 0x08 CTRL RW | 0x0C STATUS RO

module apb_top (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        transfer,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] apb_waddr,
  input  logic [31:0] apb_raddr,
  input  logic [31:0] apb_wdata,
  output logic [31:0] apb_rdata,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [31:0] paddr, pwdata, prdata;
  logic        start, done;

  // Slave registers
  logic [31:0] tx_data, ctrl;
  logic        tx_full;
  logic        addr_ok, wr_ro, reg_wr;

  // ---------------- master ----------------
  assign start = (state == IDLE) && transfer && (read || write);
  assign done  = (state == ACCESS) && pready;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    psel      = 1'b0;
    penable   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SETUP;
      end
      SETUP: begin
        psel      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) state_nxt = transfer ? SETUP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command is captured only when leaving IDLE; a back-to-back transfer
  // reissues the same command, so input changes outside IDLE are ignored.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
    end else if (start) begin
      pwrite <= write;
      paddr  <= write ? apb_waddr : apb_raddr;
      pwdata <= apb_wdata;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      apb_rdata <= '0;
      error     <= 1'b0;
    end else if (done) begin
      error <= pslverr;
      if (!pwrite) apb_rdata <= prdata;
    end
  end

  // ---------------- slave ----------------
`ifdef APB_WAIT_STATE_EN
  // Toggles through ACCESS: low on the first cycle, high on the second.
  logic wait_done;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)            wait_done <= 1'b0;
    else if (psel && penable) wait_done <= ~wait_done;
    else                     wait_done <= 1'b0;
  end

  assign pready = wait_done;
`else
  assign pready = 1'b1;
`endif

  assign addr_ok = (paddr[31:4] == 28'd0) && (paddr[1:0] == 2'b00);
  // Bit 2 set selects RX_DATA or STATUS, both read-only.
  assign wr_ro   = pwrite && paddr[2];
  assign pslverr = psel && penable && (!addr_ok || wr_ro);
  assign reg_wr  = done && pwrite && !pslverr;

  always_comb begin
    prdata = '0;
    if (addr_ok && !pwrite) begin
      case (paddr[3:2])
        2'd0: prdata = tx_data;
        2'd1: prdata = ctrl[0] ? tx_data : 32'd0;
        2'd2: prdata = ctrl;
        2'd3: prdata = {30'd0, ctrl[2], tx_full};
        default: prdata = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_data <= '0;
      ctrl    <= '0;
      tx_full <= 1'b0;
    end else if (reg_wr) begin
      case (paddr[3:2])
        2'd0: begin
          tx_data <= pwdata;
          tx_full <= 1'b1;
        end
        2'd2: begin
          ctrl <= pwdata;
          if (pwdata[1]) tx_full <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_top.sv
module tb_apb_top;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        transfer, read, write;
  logic [31:0] apb_waddr, apb_raddr, apb_wdata;
  logic [31:0] apb_rdata;
  logic        error;

`ifdef APB_WAIT_STATE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: register contents and last-completion results.
  logic [31:0] m_tx, m_ctrl, m_rd;
  logic        m_full, m_err;

  apb_top dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .transfer  (transfer),
    .read      (read),
    .write     (write),
    .apb_waddr (apb_waddr),
    .apb_raddr (apb_raddr),
    .apb_wdata (apb_wdata),
    .apb_rdata (apb_rdata),
    .error     (error)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tx = 0; m_ctrl = 0; m_full = 0; m_rd = 0; m_err = 0;
  endtask

  // Applies one transfer to the model following the register-map rules.
  task automatic model_xfer(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic bad;
    bad = (a > 32'h0C) || (a % 4 != 0) || (w && (a == 32'h04 || a == 32'h0C));
    m_err = bad;
    if (!w) begin
      if (bad)               m_rd = 0;
      else if (a == 32'h00)  m_rd = m_tx;
      else if (a == 32'h04)  m_rd = m_ctrl[0] ? m_tx : 0;
      else if (a == 32'h08)  m_rd = m_ctrl;
      else                   m_rd = (m_ctrl[2] ? 32'd2 : 32'd0) + (m_full ? 32'd1 : 32'd0);
    end else if (!bad) begin
      if (a == 32'h00) begin m_tx = d; m_full = 1; end
      else begin
        m_ctrl = d;
        if (d[1]) m_full = 0;
      end
    end
  endtask

  // Full transfer with latency and bus-phase checks; inputs are scrambled
  // once the command has been taken to confirm they are ignored.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] prev_rd;
    logic        prev_err;
    prev_rd  = m_rd;
    prev_err = m_err;
    model_xfer(w, a, d);
    @(negedge PCLK);
    transfer  = 1'b1;
    write     = w;
    read      = ~w;
    apb_waddr = w ? a : $urandom;
    apb_raddr = w ? $urandom : a;
    apb_wdata = d;
    @(posedge PCLK); #1;
    chk("setup_phase", {30'd0, dut.psel, dut.penable}, 32'd2);
    @(negedge PCLK);
    transfer  = 1'b0;
    write     = 1'($urandom);
    read      = 1'($urandom);
    apb_waddr = $urandom;
    apb_raddr = $urandom;
    apb_wdata = $urandom;
    for (int e = 2; e <= LAT; e++) begin
      @(posedge PCLK); #1;
      if (e < LAT) begin
        chk("access_phase", {30'd0, dut.psel, dut.penable}, 32'd3);
        chk("rdata_early", apb_rdata, prev_rd);
        chk("error_early", {31'd0, error}, {31'd0, prev_err});
      end else begin
        chk("idle_after", {30'd0, dut.psel, dut.penable}, 32'd0);
        chk("rdata", apb_rdata, m_rd);
        chk("error", {31'd0, error}, {31'd0, m_err});
      end
    end
  endtask

  initial begin
    logic [31:0] a, d;
    logic        w;
    int          k;

    PRESETn = 1'b0; transfer = 0; read = 0; write = 0;
    apb_waddr = 0; apb_raddr = 0; apb_wdata = 0;
    model_reset();
    #1;
    chk("rst_rdata", apb_rdata, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_psel", {31'd0, dut.psel}, 32'd0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;

    // Basic TX write and readback, STATUS tx_full
    xfer(1, 32'h00, 32'hA5);
    xfer(0, 32'h00, 32'h0);
    chk("tx_readback", apb_rdata, 32'h000000A5);
    xfer(0, 32'h0C, 32'h0);
    chk("status_full", apb_rdata, 32'h1);

    // Loopback and enable
    xfer(1, 32'h08, 32'h05);
    xfer(0, 32'h04, 32'h0);
    chk("rx_loopback", apb_rdata, 32'hA5);
    xfer(0, 32'h0C, 32'h0);
    chk("status_en", apb_rdata, 32'h3);

    // Erroring writes leave registers alone
    xfer(1, 32'h10, 32'hFFFF_FFFF);
    chk("err_range", {31'd0, error}, 32'd1);
    xfer(1, 32'h02, 32'hFFFF_FFFF);
    chk("err_align", {31'd0, error}, 32'd1);
    xfer(1, 32'h0C, 32'hFFFF_FFFF);
    chk("err_ro", {31'd0, error}, 32'd1);
    xfer(0, 32'h08, 32'h0);
    chk("ctrl_kept", apb_rdata, 32'h05);

    // Back-to-back: transfer held high six cycles; late address changes ignored
    @(negedge PCLK);
    transfer = 1; write = 1; read = 0; apb_waddr = 32'h00; apb_wdata = 32'h1234;
    for (int c = 0; c < 6; c++) begin
      @(posedge PCLK); #1;
      chk("b2b_psel", {31'd0, dut.psel}, 32'd1);
      @(negedge PCLK);
      apb_waddr = 32'h08; apb_wdata = $urandom; read = 1'($urandom);
    end
    transfer = 0;
    k = 0;
    while (dut.psel && k < 4) begin
      @(posedge PCLK); #1;
      k++;
    end
    chk("b2b_end_idle", {31'd0, dut.psel}, 32'd0);
    model_xfer(1, 32'h00, 32'h1234);
    chk("b2b_error", {31'd0, error}, 32'd0);
    xfer(0, 32'h08, 32'h0);
    xfer(0, 32'h00, 32'h0);
    chk("b2b_tx", apb_rdata, 32'h1234);

    // Randomized transfers against the model
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom);
      case ($urandom_range(0, 7))
        0: a = 32'h00;
        1: a = 32'h04;
        2: a = 32'h08;
        3: a = 32'h0C;
        4: a = 32'h10 + 32'($urandom_range(0, 15)) * 4;
        5: a = 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(1, 3));
        6: a = $urandom;
        default: a = 32'h00;
      endcase
      d = $urandom;
      xfer(w, a, d);
    end

    // Reset during SETUP of a CTRL write
    xfer(0, 32'h10, 32'h0);
    @(negedge PCLK);
    transfer = 1; write = 1; read = 0; apb_waddr = 32'h08; apb_wdata = 32'hFF;
    @(posedge PCLK); #1;
    chk("mid_setup", {30'd0, dut.psel, dut.penable}, 32'd2);
    PRESETn = 1'b0;
    #1;
    chk("mid_rst_bus", {30'd0, dut.psel, dut.penable}, 32'd0);
    chk("mid_rst_rdata", apb_rdata, 32'd0);
    chk("mid_rst_error", {31'd0, error}, 32'd0);
    @(negedge PCLK);
    transfer = 0; write = 0;
    model_reset();
    @(negedge PCLK);
    PRESETn = 1'b1;
    xfer(0, 32'h08, 32'h0);
    chk("ctrl_after_rst", apb_rdata, 32'd0);
    xfer(0, 32'h0C, 32'h0);
    chk("status_after_rst", apb_rdata, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
